// File: rtl/ram_seno_axil_loader.sv
// AXI4-Lite master: writes word[i] = seed + i to N consecutive words of the
// target slave, reads them back, and reports completion, a sticky error flag
// and a saturating failing-word count.
module ram_seno_axil_loader #(
  parameter int unsigned                    C_M_AXI_ADDR_WIDTH         = 32,
  parameter int unsigned                    C_M_AXI_DATA_WIDTH         = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]  C_M_TARGET_SLAVE_BASE_ADDR = '0,
  parameter int unsigned                    C_M_TRANSACTIONS_NUM       = 4
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              INIT_AXI_TXN,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     START_DATA,
  output logic                              BUSY,
  output logic                              TXN_DONE,
  output logic                              ERROR,
  output logic [7:0]                        ERR_COUNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam logic [7:0]  LAST = 8'(C_M_TRANSACTIONS_NUM - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t          state, state_next;
  logic            init_q, start;
  logic [DW-1:0]   seed;
  logic [7:0]      idx, idx_inc;
  logic [AW-1:0]   addr_inc;
  logic [DW-1:0]   data_inc, data_exp;
  logic            aw_done, w_done, ar_done;
  logic            aw_hs, w_hs, b_hs, ar_hs, r_hs, last, err_hit;
  logic            unused_resp;

  assign M_AXI_AWPROT = '0;
  assign M_AXI_ARPROT = '0;
  assign M_AXI_WSTRB  = '1;

  assign start    = (state == IDLE) && INIT_AXI_TXN && !init_q;
  assign aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs     = M_AXI_WVALID  && M_AXI_WREADY;
  assign b_hs     = M_AXI_BVALID  && M_AXI_BREADY;
  assign ar_hs    = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs     = M_AXI_RVALID  && M_AXI_RREADY;
  assign last     = (idx == LAST);
  assign idx_inc  = idx + 8'd1;
  assign addr_inc = C_M_TARGET_SLAVE_BASE_ADDR + (AW'(idx_inc) << 2);
  assign data_inc = seed + DW'(idx_inc);
  assign data_exp = seed + DW'(idx);

  // A failing word counts once even when both data and response are bad.
  assign err_hit = ((state == WRITE) && b_hs && M_AXI_BRESP[1]) ||
                   ((state == READ)  && r_hs && ((M_AXI_RDATA != data_exp) || M_AXI_RRESP[1]));

  assign unused_resp = ^{M_AXI_BRESP[0], M_AXI_RRESP[0]};

  // State register.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) state <= IDLE;
    else                state <= state_next;
  end

  // Next-state decode: one transaction at a time, phase advances on B/R handshakes.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)        state_next = WRITE;
      WRITE:   if (b_hs && last) state_next = READ;
      READ:    if (r_hs && last) state_next = DONE;
      DONE:                      state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // Registered channel outputs, pattern index and status.
  // The ready for B/R is raised one cycle after the address (and data) handshakes
  // complete, giving three cycles per transaction against a zero-wait slave.
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      init_q        <= 1'b1;
      seed          <= '0;
      idx           <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      ar_done       <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_ARADDR  <= '0;
      BUSY          <= 1'b0;
      TXN_DONE      <= 1'b0;
      ERROR         <= 1'b0;
      ERR_COUNT     <= '0;
    end else begin
      init_q   <= INIT_AXI_TXN;
      TXN_DONE <= 1'b0;
      if (err_hit) begin
        ERROR <= 1'b1;
        if (ERR_COUNT != '1) ERR_COUNT <= ERR_COUNT + 8'd1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            seed          <= START_DATA;
            idx           <= '0;
            ERROR         <= 1'b0;
            ERR_COUNT     <= '0;
            BUSY          <= 1'b1;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_AWADDR  <= C_M_TARGET_SLAVE_BASE_ADDR;
            M_AXI_WDATA   <= START_DATA;
          end
        end
        WRITE: begin
          if (aw_hs) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            M_AXI_WVALID <= 1'b0;
            w_done       <= 1'b1;
          end
          if (aw_done && w_done && !M_AXI_BREADY) M_AXI_BREADY <= 1'b1;
          if (b_hs) begin
            M_AXI_BREADY <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            if (last) begin
              idx           <= '0;
              M_AXI_ARVALID <= 1'b1;
              M_AXI_ARADDR  <= C_M_TARGET_SLAVE_BASE_ADDR;
            end else begin
              idx           <= idx_inc;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              M_AXI_AWADDR  <= addr_inc;
              M_AXI_WDATA   <= data_inc;
            end
          end
        end
        READ: begin
          if (ar_hs) begin
            M_AXI_ARVALID <= 1'b0;
            ar_done       <= 1'b1;
          end
          if (ar_done && !M_AXI_RREADY) M_AXI_RREADY <= 1'b1;
          if (r_hs) begin
            M_AXI_RREADY <= 1'b0;
            ar_done      <= 1'b0;
            if (!last) begin
              idx           <= idx_inc;
              M_AXI_ARVALID <= 1'b1;
              M_AXI_ARADDR  <= addr_inc;
            end
          end
        end
        DONE: begin
          TXN_DONE <= 1'b1;
          BUSY     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_seno_axil_loader.sv
// Directed bench for ram_seno_axil_loader with a small AXI4-Lite RAM slave
// (configurable ready delays and injected errors) and a protocol monitor.
module tb_ram_seno_axil_loader;

  logic        clk = 1'b0;
  logic        rstn, init;
  logic [31:0] start_data;
  logic        busy, txn_done, error;
  logic [7:0]  err_count;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  always #5 clk = ~clk;

  ram_seno_axil_loader #(
    .C_M_AXI_ADDR_WIDTH        (32),
    .C_M_AXI_DATA_WIDTH        (32),
    .C_M_TARGET_SLAVE_BASE_ADDR(32'h0000_0000),
    .C_M_TRANSACTIONS_NUM      (4)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rstn),
    .INIT_AXI_TXN (init),
    .START_DATA   (start_data),
    .BUSY         (busy),
    .TXN_DONE     (txn_done),
    .ERROR        (error),
    .ERR_COUNT    (err_count),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWPROT (awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARPROT (arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready)
  );

  // ---------------- slave model ----------------
  int unsigned aw_delay = 0, w_delay = 0;
  int unsigned aw_wait, w_wait;
  int n_aw = 0, n_w = 0, n_bi = 0, n_b = 0, n_ar = 0, n_r = 0, n_done = 0, viol = 0;
  int bslv_at = -1, rbad_at = -1, rslv_at = -1;
  logic        got_aw, got_w;
  logic [31:0] cap_addr, cap_data;
  logic [31:0] mem   [0:63];
  logic [31:0] wlog  [0:63];
  logic [31:0] alog  [0:63];
  logic [31:0] arlog [0:63];

  assign awready = awvalid && (aw_wait >= aw_delay);
  assign wready  = wvalid  && (w_wait  >= w_delay);
  assign arready = arvalid;

  always @(posedge clk) begin
    if (!rstn) begin
      got_aw <= 1'b0; got_w <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      aw_wait <= 0; w_wait <= 0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait  <= (wvalid  && !wready)  ? w_wait  + 1 : 0;
      if (awvalid && awready) begin
        got_aw <= 1'b1; cap_addr <= awaddr; alog[n_aw[5:0]] <= awaddr; n_aw <= n_aw + 1;
      end
      if (wvalid && wready) begin
        got_w <= 1'b1; cap_data <= wdata; wlog[n_w[5:0]] <= wdata; n_w <= n_w + 1;
      end
      if (got_aw && got_w && !bvalid) begin
        mem[cap_addr[7:2]] <= cap_data;
        bresp  <= (n_bi == bslv_at) ? 2'b10 : 2'b00;
        bvalid <= 1'b1; got_aw <= 1'b0; got_w <= 1'b0; n_bi <= n_bi + 1;
      end
      if (bvalid && bready) begin bvalid <= 1'b0; n_b <= n_b + 1; end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= (n_ar == rbad_at) ? 32'hDEAD_BEEF : mem[araddr[7:2]];
        rresp  <= (n_ar == rslv_at) ? 2'b10 : 2'b00;
        arlog[n_ar[5:0]] <= araddr; n_ar <= n_ar + 1;
      end
      if (rvalid && rready) begin rvalid <= 1'b0; n_r <= n_r + 1; end
    end
  end

  // ---------------- protocol monitor ----------------
  logic pend_aw = 1'b0, pend_w = 1'b0, pend_ar = 1'b0;
  logic drop_aw = 1'b0, drop_w = 1'b0, drop_ar = 1'b0;
  logic [31:0] hold_awaddr, hold_wdata, hold_araddr;
  logic v_aw, v_w, v_ar, v_mix;

  assign v_aw  = (pend_aw && (!awvalid || awaddr !== hold_awaddr)) || (drop_aw && awvalid);
  assign v_w   = (pend_w  && (!wvalid  || wdata  !== hold_wdata))  || (drop_w  && wvalid);
  assign v_ar  = (pend_ar && (!arvalid || araddr !== hold_araddr)) || (drop_ar && arvalid);
  assign v_mix = arvalid && (awvalid || wvalid || bready);

  always @(posedge clk) begin
    if (txn_done) n_done <= n_done + 1;
    if (!rstn) begin
      pend_aw <= 1'b0; pend_w <= 1'b0; pend_ar <= 1'b0;
      drop_aw <= 1'b0; drop_w <= 1'b0; drop_ar <= 1'b0;
    end else begin
      viol <= viol + int'(v_aw) + int'(v_w) + int'(v_ar) + int'(v_mix);
      pend_aw <= awvalid && !awready; hold_awaddr <= awaddr; drop_aw <= awvalid && awready;
      pend_w  <= wvalid  && !wready;  hold_wdata  <= wdata;  drop_w  <= wvalid  && wready;
      pend_ar <= arvalid && !arready; hold_araddr <= araddr; drop_ar <= arvalid && arready;
    end
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0, n_bad = 0;
  int b_aw, b_w, b_b, b_ar, b_r, b_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic snap();
    b_aw = n_aw; b_w = n_w; b_b = n_b; b_ar = n_ar; b_r = n_r; b_done = n_done;
  endtask

  task automatic start(input logic [31:0] seed);
    start_data = seed;
    snap();
    init = 1'b1;
    tick(1);
    init = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int c;
    c = 0;
    while (txn_done !== 1'b1 && c < limit) begin tick(1); c++; end
    chk(tag, txn_done, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rstn = 1'b0; init = 1'b0; start_data = '0;
    tick(3);
    chk("rst_ctrl", {awvalid, wvalid, bready, arvalid, rready, busy, txn_done, error}, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_araddr", araddr, 0);
    rstn = 1'b1;
    tick(2);

    // pass case: seed 1, zero-wait slave, exact latency
    start(32'h1);
    chk("t1_start_valid", {awvalid, wvalid, busy}, 3'b111);
    chk("t1_awaddr0", awaddr, 0);
    chk("t1_wdata0", wdata, 1);
    chk("t1_wstrb", wstrb, 4'hF);
    chk("t1_prot", {awprot, arprot}, 0);
    for (int k = 1; k <= 26; k++) begin
      tick(1);
      if (k == 1)  chk("t1_valid_drop", {awvalid, wvalid}, 0);
      if (k == 2)  chk("t1_bready", bready, 1);
      if (k == 12) chk("t1_ar_issue", {arvalid, awvalid}, 2'b10);
      if (k == 24) chk("t1_done_early", {txn_done, busy}, 2'b01);
      if (k == 25) begin
        chk("t1_done_pulse", txn_done, 1);
        chk("t1_error", error, 0);
        chk("t1_errcnt", err_count, 0);
      end
      if (k == 26) chk("t1_done_end", {txn_done, busy}, 0);
    end
    for (int i = 0; i < 4; i++) begin
      chk("t1_wr_data", wlog[6'(b_w + i)], 32'(1 + i));
      chk("t1_wr_addr", alog[6'(b_aw + i)], 32'(4 * i));
      chk("t1_rd_addr", arlog[6'(b_ar + i)], 32'(4 * i));
    end
    chk("t1_n_b", n_b - b_b, 4);
    chk("t1_n_r", n_r - b_r, 4);
    chk("t1_n_done", n_done - b_done, 1);

    // independent AW/W handshakes: AW late, then W late
    aw_delay = 3; w_delay = 0;
    start(32'h100);
    wait_done("t2a_done", 200);
    chk("t2a_error", error, 0);
    for (int i = 0; i < 4; i++) chk("t2a_wr_data", wlog[6'(b_w + i)], 32'h100 + 32'(i));
    chk("t2a_n_aw", n_aw - b_aw, 4);
    chk("t2a_n_b", n_b - b_b, 4);
    tick(2);
    aw_delay = 0; w_delay = 3;
    start(32'h200);
    wait_done("t2b_done", 200);
    chk("t2b_error", error, 0);
    for (int i = 0; i < 4; i++) chk("t2b_wr_addr", alog[6'(b_aw + i)], 32'(4 * i));
    chk("t2b_n_w", n_w - b_w, 4);
    chk("t2b_n_b", n_b - b_b, 4);
    chk("t2_protocol", viol, 0);
    tick(2);

    // corrupted read data on word 2, SLVERR on word 3
    w_delay = 0;
    rbad_at = n_ar + 2; rslv_at = n_ar + 3;
    start(32'h10);
    wait_done("t3_done", 200);
    chk("t3_error", error, 1);
    chk("t3_errcnt", err_count, 2);
    rbad_at = -1; rslv_at = -1;
    tick(2);

    // wrap-around data and SLVERR on the first write
    bslv_at = n_bi;
    start(32'hFFFF_FFFE);
    wait_done("t4_done", 200);
    chk("t4_wr0", wlog[6'(b_w + 0)], 32'hFFFF_FFFE);
    chk("t4_wr1", wlog[6'(b_w + 1)], 32'hFFFF_FFFF);
    chk("t4_wr2", wlog[6'(b_w + 2)], 32'h0000_0000);
    chk("t4_wr3", wlog[6'(b_w + 3)], 32'h0000_0001);
    chk("t4_error", error, 1);
    chk("t4_errcnt", err_count, 1);
    bslv_at = -1;
    tick(2);

    // reset while AWVALID waits on AWREADY; INIT held high across reset
    aw_delay = 10;
    start_data = 32'h55;
    snap();
    init = 1'b1;
    tick(1);
    chk("t5_start_clears", {error, err_count}, 0);
    tick(2);
    chk("t5_aw_held", {awvalid, awready}, 2'b10);
    rstn = 1'b0;
    tick(1);
    chk("t5_rst_valids", {awvalid, wvalid, arvalid, bready, rready, busy}, 0);
    rstn = 1'b1;
    tick(5);
    chk("t5_no_restart", {busy, awvalid}, 0);
    chk("t5_n_aw", n_aw - b_aw, 0);
    init = 1'b0; aw_delay = 0;
    tick(2);
    snap();
    init = 1'b1;
    tick(1);
    chk("t5_restart", {busy, awvalid, wvalid}, 3'b111);
    chk("t5_wdata0", wdata, 32'h55);
    init = 1'b0;
    wait_done("t5_done", 200);
    chk("t5_error", error, 0);
    chk("t5_n_b", n_b - b_b, 4);
    tick(2);

    // start pulse during READ is ignored
    start(32'h300);
    tick(14);
    init = 1'b1;
    tick(1);
    init = 1'b0;
    tick(40);
    chk("t6_n_done", n_done - b_done, 1);
    chk("t6_n_aw", n_aw - b_aw, 4);
    chk("t6_n_ar", n_ar - b_ar, 4);
    chk("t6_idle", busy, 0);
    chk("protocol_all", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
